// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding,
// latency counter width, alignment mask and default bus widths.
package dmem_responder_pkg;

    localparam int DMEM_ADDR_LEN = 32;
    localparam int DMEM_DATA_LEN = 32;

    // Wide enough for LATENCY up to 15.
    localparam int CNT_W = 4;

    // Low byte-address bits that must be zero for a word access.
    localparam logic [1:0] ALIGN_MASK = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/dmem_sram_array.sv
// Single-port word array: synchronous write, registered read, no reset.
module dmem_sram_array #(
    parameter int DEPTH_WORDS = 256,
    parameter int DATA_LEN    = 32,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic                clk,
    input  logic                we,
    input  logic                re,
    input  logic [IDX_W-1:0]    addr,
    input  logic [DATA_LEN-1:0] wdata,
    output logic [DATA_LEN-1:0] rdata
);

    logic [DATA_LEN-1:0] mem [DEPTH_WORDS];

    // Write and read share the one port; rdata only changes on a read so it
    // stays stable while the responder holds a response.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage load/store responder: one outstanding word request, fixed
// access latency, error response for misaligned or out-of-range addresses.
//
// Handshakes: a transfer happens on a rising edge where valid && ready.
// req_ready is high only in IDLE; rsp_valid is high only in RESP, and the
// response payload (rsp_rdata, rsp_err) is constant while rsp_valid waits
// for rsp_ready. The FSM state is visible as the internal signal 'state'.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int ADDR_LEN    = DMEM_ADDR_LEN,
    parameter int DATA_LEN    = DMEM_DATA_LEN,
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [ADDR_LEN-1:0] req_addr,
    input  logic [DATA_LEN-1:0] req_wdata,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_LEN-1:0] rsp_rdata,
    output logic                rsp_err
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    generate
        if ((LATENCY < 1) || (LATENCY > 15)) begin : g_bad_latency
            $error("dmem_responder: LATENCY must be in 1..15");
        end
    endgenerate

    state_t              state, state_nxt;
    logic [CNT_W-1:0]    cnt_q, cnt_nxt;
    logic                accept;
    logic                access;

    logic                write_q;
    logic [IDX_W-1:0]    idx_q;
    logic [DATA_LEN-1:0] wdata_q;
    logic                err_q;

    logic                req_err;
    logic                cur_write;
    logic [IDX_W-1:0]    cur_idx;
    logic [DATA_LEN-1:0] cur_wdata;
    logic                cur_err;

    logic                rsp_err_q;
    logic                rsp_load_q;
    logic                sram_we;
    logic                sram_re;
    logic [DATA_LEN-1:0] sram_rdata;

    // Address check: any low bit set, or any bit above the array index
    // (DEPTH_WORDS is a power of two, so that means word >= DEPTH_WORDS).
    always_comb begin
        req_err = ((req_addr[1:0] & ALIGN_MASK) != 2'b00) ||
                  (req_addr[ADDR_LEN-1:IDX_W+2] != '0);
    end

    // Access operands: straight from the request when LATENCY == 1 (access
    // happens on the accept edge), otherwise from the latched copy.
    always_comb begin
        if (state == IDLE) begin
            cur_write = req_write;
            cur_idx   = req_addr[IDX_W+1:2];
            cur_wdata = req_wdata;
            cur_err   = req_err;
        end else begin
            cur_write = write_q;
            cur_idx   = idx_q;
            cur_wdata = wdata_q;
            cur_err   = err_q;
        end
    end

    // State and latency counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt_q <= '0;
        end else begin
            state <= state_nxt;
            cnt_q <= cnt_nxt;
        end
    end

    // Next state, counter and handshake outputs. The counter is loaded with
    // LATENCY-1 and the access fires on the edge that takes it to zero,
    // which places rsp_valid exactly LATENCY cycles after acceptance.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt_q;
        accept    = 1'b0;
        access    = 1'b0;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept  = 1'b1;
                    cnt_nxt = CNT_W'(LATENCY - 1);
                    if (LATENCY == 1) begin
                        access    = 1'b1;
                        state_nxt = RESP;
                    end else begin
                        state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_nxt = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    access    = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Capture the request on acceptance; inputs are ignored afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            write_q <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
        end else if (accept) begin
            write_q <= req_write;
            idx_q   <= req_addr[IDX_W+1:2];
            wdata_q <= req_wdata;
            err_q   <= req_err;
        end
    end

    // Remember the response kind decided on the access edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_err_q  <= 1'b0;
            rsp_load_q <= 1'b0;
        end else if (access) begin
            rsp_err_q  <= cur_err;
            rsp_load_q <= !cur_write && !cur_err;
        end
    end

    // Errored accesses never touch the array.
    always_comb begin
        sram_we = access && cur_write && !cur_err;
        sram_re = access && !cur_write && !cur_err;
    end

    dmem_sram_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .DATA_LEN    (DATA_LEN),
        .IDX_W       (IDX_W)
    ) u_array (
        .clk   (clk),
        .we    (sram_we),
        .re    (sram_re),
        .addr  (cur_idx),
        .wdata (cur_wdata),
        .rdata (sram_rdata)
    );

    // Response payload is zero outside RESP and for stores/errors, so the
    // unreset array output never leaks onto the bus.
    always_comb begin
        rsp_rdata = (state == RESP && rsp_load_q) ? sram_rdata : '0;
        rsp_err   = (state == RESP) && rsp_err_q;
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder with the default LATENCY of 2.
module tb_dmem_responder;
    import dmem_responder_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int checks = 0;
    int errors = 0;

    dmem_responder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Full transaction with rsp_ready high; starts and ends 1ns after an edge in IDLE.
    task automatic transact(input string tag, input logic wr, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [31:0] exp_rdata,
                            input logic exp_err);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wdata;
        rsp_ready = 1'b1;
        step();
        req_valid = 1'b0;
        check({tag, ".valid_early"}, 32'(rsp_valid), 32'd0);
        check({tag, ".ready_busy"},  32'(req_ready), 32'd0);
        step();
        check({tag, ".valid"}, 32'(rsp_valid), 32'd1);
        check({tag, ".rdata"}, rsp_rdata, exp_rdata);
        check({tag, ".err"},   32'(rsp_err), 32'(exp_err));
        step();
        check({tag, ".valid_clr"}, 32'(rsp_valid), 32'd0);
        check({tag, ".ready_back"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        rsp_ready = 1'b0;

        // Reset
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("rst.req_ready", 32'(req_ready), 32'd1);
        check("rst.rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst.rsp_rdata", rsp_rdata, 32'd0);
        check("rst.rsp_err",   32'(rsp_err), 32'd0);
        check("rst.state",     32'(dut.state), 32'(IDLE));

        // Store then load back
        transact("st10", 1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
        transact("ld10", 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);

        // Error accesses
        transact("ld12_mis", 1'b0, 32'h12, 32'h0, 32'h0, 1'b1);
        transact("ld400_oor", 1'b0, 32'h400, 32'h0, 32'h0, 1'b1);
        transact("st12_mis", 1'b1, 32'h12, 32'h0BAD0BAD, 32'h0, 1'b1);
        transact("st410_oor", 1'b1, 32'h410, 32'h0BAD0BAD, 32'h0, 1'b1);
        transact("ld10_after_err", 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);

        // Seed 0x20 and 0x24
        transact("st20", 1'b1, 32'h20, 32'h11111111, 32'h0, 1'b0);
        transact("st24", 1'b1, 32'h24, 32'h24242424, 32'h0, 1'b0);
        transact("ld20", 1'b0, 32'h20, 32'h0, 32'h11111111, 1'b0);

        // Backpressure on load of 0x10
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 32'h10;
        rsp_ready = 1'b0;
        step();
        req_valid = 1'b0;
        step();
        check("bp.valid", 32'(rsp_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp.hold_valid", 32'(rsp_valid), 32'd1);
            check("bp.hold_rdata", rsp_rdata, 32'hDEADBEEF);
            check("bp.hold_ready", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        step();
        check("bp.release_valid", 32'(rsp_valid), 32'd0);
        check("bp.release_ready", 32'(req_ready), 32'd1);
        check("bp.release_state", 32'(dut.state), 32'(IDLE));

        // Request inputs change while waiting
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 32'h20;
        step();
        req_addr  = 32'h24;
        req_write = 1'b1;
        req_wdata = 32'hCAFEF00D;
        check("chg.ready_wait", 32'(req_ready), 32'd0);
        step();
        req_valid = 1'b0;
        check("chg.valid", 32'(rsp_valid), 32'd1);
        check("chg.rdata", rsp_rdata, 32'h11111111);
        check("chg.err",   32'(rsp_err), 32'd0);
        step();
        check("chg.state_idle", 32'(dut.state), 32'(IDLE));
        step();
        check("chg.no_extra", 32'(rsp_valid), 32'd0);
        transact("ld24_untouched", 1'b0, 32'h24, 32'h0, 32'h24242424, 1'b0);

        // Reset during WAIT of a store to 0x20: store must be dropped
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 32'h20;
        req_wdata = 32'h22222222;
        rsp_ready = 1'b1;
        step();
        req_valid = 1'b0;
        check("rstw.in_wait", 32'(dut.state), 32'(WAIT));
        rst_n = 1'b0;
        #1;
        check("rstw.valid", 32'(rsp_valid), 32'd0);
        check("rstw.state", 32'(dut.state), 32'(IDLE));
        check("rstw.ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        transact("ld20_after_rst", 1'b0, 32'h20, 32'h0, 32'h11111111, 1'b0);

        // Reset after the access edge of a store to 0x30: store must remain
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 32'h30;
        req_wdata = 32'h33333333;
        rsp_ready = 1'b0;
        step();
        req_valid = 1'b0;
        step();
        check("rstr.valid", 32'(rsp_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rstr.valid_clr", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        transact("ld30_kept", 1'b0, 32'h30, 32'h0, 32'h33333333, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
